load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MAX_WAIT, default 15, memory-side cycles tolerated in ISSUE or WAIT before timeout error.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  core presents access.
REQ-005 req_ready  out  1  unit accepts access; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  valid with rsp_valid; misaligned, illegal funct3 or timeout.
REQ-013 mem_req  out  1  word request to data memory.
REQ-014 mem_we  out  1  write strobe.
REQ-015 mem_addr  out  32  word-aligned address, bits [1:0] = 00.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_gnt  in  1  memory accepted request this cycle.
REQ-019 mem_rvalid  in  1  load data valid this cycle.
REQ-020 mem_rdata  in  32  raw word from memory.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; accept = req_valid & req_ready in IDLE; all request fields registered on accept.
REQ-022 IDLE->ISSUE on legal, aligned accept; IDLE->RESP with error on illegal or misaligned accept; no mem_req issued for errors.
REQ-023 Illegal: funct3 011/110/111; store with funct3[2]=1.
REQ-024 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-025 ISSUE: mem_req=1, fields stable until mem_gnt; gnt on store -> RESP; gnt on load -> WAIT.
REQ-026 WAIT: mem_req=0; mem_rvalid -> capture extended data, -> RESP; mem_rvalid outside WAIT ignored.
REQ-027 Wait counter clears on entering ISSUE and WAIT; counter reaching MAX_WAIT without gnt/rvalid -> RESP, rsp_err=1, rsp_rdata=0, mem_req dropped.
REQ-028 RESP lasts exactly one cycle: rsp_valid=1, then IDLE; back-to-back accept allowed in following cycle.
REQ-029 Min latency accept->rsp_valid: store 2 cycles (gnt same cycle as first mem_req), load 3 cycles (rvalid cycle after gnt), error 1 cycle.
REQ-030 Store B: mem_be = 0001 << addr[1:0], mem_wdata = wdata[7:0] in all 4 lanes.
REQ-031 Store H: mem_be = 0011 << addr[1:0], mem_wdata = wdata[15:0] in both halves; W: be=1111, wdata unchanged.
REQ-032 Load: mem_be=1111; lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-033 Outside ISSUE: mem_req, mem_we, mem_be, mem_wdata, mem_addr driven 0.

Reset
REQ-034 reset in any state -> IDLE next cycle; in-flight access abandoned, no rsp_valid; pending gnt/rvalid in reset cycle ignored.
REQ-035 Reset values: req_ready=0 during reset cycle then 1, rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* outputs 0, wait counter 0.

Verification
REQ-036 SB addr=0x103, wdata=0x000000A5, gnt immediate -> mem_addr=0x100, be=1000, wdata=0xA5A5A5A5; rsp_valid 2 cycles after accept, err=0.
REQ-037 LB addr=0x102, mem_rdata=0x12F45678 -> rsp_rdata=0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr=0x102 -> 0x000012F4.
REQ-038 LW addr=0x101 -> rsp_err=1 one cycle after accept, mem_req never asserted; funct3=011 -> same.
REQ-039 mem_gnt held low, MAX_WAIT=15 -> mem_req high 15 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-040 reset asserted in WAIT with mem_rvalid=1 same cycle -> no rsp_valid, IDLE next cycle, all outputs at reset values.
REQ-041 Two back-to-back SW (0x200, 0x204) with gnt held high -> two responses, each 2 cycles after its accept, be=1111.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time, aligns and
// replicates store data onto a word-wide memory port, extracts and extends
// load data, and reports misaligned, illegal or timed-out accesses.
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned   CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          badAccess;
    logic [31:0]   laneWord;
    logic [31:0]   loadData;
    logic [3:0]    accessBe;
    logic [31:0]   storeData;

    // Classify the incoming request: illegal width codes and misaligned addresses never reach memory.
    always_comb begin
        badAccess = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            badAccess = 1'b1;
        if (req_we && req_funct3[2])
            badAccess = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            badAccess = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            badAccess = 1'b1;
    end

    // Byte enables and lane-replicated data for the registered access; loads always read the whole word.
    always_comb begin
        accessBe  = 4'b1111;
        storeData = wdata_q;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    accessBe  = 4'b0001 << addr_q[1:0];
                    storeData = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    accessBe  = 4'b0011 << addr_q[1:0];
                    storeData = {2{wdata_q[15:0]}};
                end
                default: begin
                    accessBe  = 4'b1111;
                    storeData = wdata_q;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and sign- or zero-extend it.
    always_comb begin
        laneWord = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b100:  loadData = {24'b0, laneWord[7:0]};
            3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b101:  loadData = {16'b0, laneWord[15:0]};
            default: loadData = laneWord;
        endcase
    end

    // Drive the core and memory sides from the current state; reset forces everything quiet.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_be    = 4'b0;
        mem_wdata = 32'b0;
        if (!reset) begin
            req_ready = (state_q == IDLE);
            if (state_q == RESP) begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
            end
            if (state_q == ISSUE) begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = accessBe;
                mem_wdata = we_q ? storeData : 32'b0;
            end
        end
    end

    assign accept = req_valid && req_ready;

    // Next-state logic: sequence each access and bound every memory wait with the timeout counter.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    rdata_d  = 32'b0;
                    err_d    = badAccess;
                    state_d  = badAccess ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? RESP : WAIT;
                end else if (cnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    rdata_d = 32'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = loadData;
                    state_d = RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    rdata_d = 32'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses against a transaction-level
// model of expected per-cycle outputs, plus literal spot checks.
module tb_load_store_unit;

    localparam int MAXW = 15;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks;
    int failures;
    int cycleCount;
    int acceptCycle;
    logic checkEn;

    logic        expReady;
    logic        expRspValid;
    logic        expRspErr;
    logic [31:0] expRspRdata;
    logic        expMemReq;
    logic        expMemWe;
    logic [31:0] expMemAddr;
    logic [3:0]  expMemBe;
    logic [31:0] expMemWdata;

    int          rspCount;
    int          memReqCycles;
    int          lastLatency;
    logic        lastRspErr;
    logic [31:0] lastRspRdata;
    logic [31:0] lastAddr;
    logic [3:0]  lastBe;
    logic [31:0] lastWdata;

    logic gntHold;
    logic strayRv;
    int   base;

    load_store_unit #(.MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Access width in bytes for a funct3 code, 0 when the code is not a valid width.
    function automatic int modelSize(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic modelIsError(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = modelSize(f3);
        if (sz == 0) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = modelSize(f3);
        if (!we) return 4'hF;
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wdata);
        int sz;
        logic [31:0] b;
        sz = modelSize(f3);
        if (sz == 1) begin
            b = {24'b0, wdata[7:0]};
            return b * 32'h01010101;
        end
        if (sz == 2) begin
            b = {16'b0, wdata[15:0]};
            return b * 32'h00010001;
        end
        return wdata;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz = modelSize(f3);
        v = rdata >> (8 * (addr % 4));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && ((v >> (8 * sz - 1)) & 32'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    task automatic setIdleExp(input logic rdy);
        expReady    = rdy;
        expRspValid = 1'b0;
        expRspErr   = 1'b0;
        expRspRdata = 32'b0;
        expMemReq   = 1'b0;
        expMemWe    = 1'b0;
        expMemAddr  = 32'b0;
        expMemBe    = 4'b0;
        expMemWdata = 32'b0;
    endtask

    // One complete access: accept cycle, issue phase, optional wait phase, response cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int gntDelay, input int rvDelay,
                                 input logic [31:0] rdata);
        logic        err;
        logic        tmo;
        logic        done;
        logic [31:0] result;
        int          k;
        err    = modelIsError(we, f3, addr);
        tmo    = 1'b0;
        result = 32'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        setIdleExp(1'b1);
        acceptCycle = cycleCount;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        if (!err) begin
            done = 1'b0;
            k = 0;
            while (!done && !tmo) begin
                setIdleExp(1'b0);
                expMemReq   = 1'b1;
                expMemWe    = we;
                expMemAddr  = {addr[31:2], 2'b00};
                expMemBe    = modelBe(we, f3, addr);
                expMemWdata = we ? modelWdata(f3, wdata) : 32'b0;
                mem_gnt     = gntHold || (k == gntDelay);
                mem_rvalid  = strayRv;
                mem_rdata   = strayRv ? 32'hBAD0BAD0 : 32'b0;
                @(posedge clk); #1;
                mem_gnt    = gntHold;
                mem_rvalid = 1'b0;
                if (gntHold || k == gntDelay) done = 1'b1;
                else if (k == MAXW - 1) tmo = 1'b1;
                k++;
            end
            if (done && !we) begin
                done = 1'b0;
                k = 0;
                while (!done && !tmo) begin
                    setIdleExp(1'b0);
                    mem_rvalid = (k == rvDelay);
                    mem_rdata  = (k == rvDelay) ? rdata : 32'hDEADBEEF;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                    mem_rdata  = 32'b0;
                    if (k == rvDelay) begin
                        done   = 1'b1;
                        result = modelLoad(f3, addr, rdata);
                    end else if (k == MAXW - 1) begin
                        tmo = 1'b1;
                    end
                    k++;
                end
            end
        end
        setIdleExp(1'b0);
        expRspValid = 1'b1;
        expRspErr   = err || tmo;
        expRspRdata = (err || tmo || we) ? 32'b0 : result;
        @(posedge clk); #1;
        setIdleExp(1'b1);
    endtask

    // Compare every output against the model each cycle and record observations for spot checks.
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("req_ready", 32'(req_ready), 32'(expReady));
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRspValid));
                checkOutput("rsp_err", 32'(rsp_err), 32'(expRspErr));
                checkOutput("rsp_rdata", rsp_rdata, expRspRdata);
                checkOutput("mem_req", 32'(mem_req), 32'(expMemReq));
                checkOutput("mem_we", 32'(mem_we), 32'(expMemWe));
                checkOutput("mem_addr", mem_addr, expMemAddr);
                checkOutput("mem_be", 32'(mem_be), 32'(expMemBe));
                checkOutput("mem_wdata", mem_wdata, expMemWdata);
                if (rsp_valid) begin
                    rspCount++;
                    lastLatency  = cycleCount - acceptCycle;
                    lastRspErr   = rsp_err;
                    lastRspRdata = rsp_rdata;
                end
                if (mem_req) begin
                    memReqCycles++;
                    lastAddr  = mem_addr;
                    lastBe    = mem_be;
                    lastWdata = mem_wdata;
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        checks = 0; failures = 0; cycleCount = 0; acceptCycle = 0;
        rspCount = 0; memReqCycles = 0; lastLatency = 0;
        lastRspErr = 1'b0; lastRspRdata = 32'b0; lastAddr = 32'b0; lastBe = 4'b0; lastWdata = 32'b0;
        gntHold = 1'b0; strayRv = 1'b0; base = 0;
        checkEn = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
        setIdleExp(1'b0);
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        setIdleExp(1'b1);
        @(posedge clk); #1;

        $display("[TB] store byte with immediate grant");
        applyStimulus(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'b0);
        checkOutput("sb_addr", lastAddr, 32'h00000100);
        checkOutput("sb_be", 32'(lastBe), 32'h8);
        checkOutput("sb_wdata", lastWdata, 32'hA5A5A5A5);
        checkOutput("sb_latency", 32'(lastLatency), 32'd2);
        checkOutput("sb_err", 32'(lastRspErr), 32'd0);

        $display("[TB] byte and halfword loads with extension");
        applyStimulus(1'b0, 3'b000, 32'h102, 32'b0, 0, 0, 32'h12F45678);
        checkOutput("lb_rdata", lastRspRdata, 32'hFFFFFFF4);
        checkOutput("lb_latency", 32'(lastLatency), 32'd3);
        applyStimulus(1'b0, 3'b100, 32'h102, 32'b0, 0, 0, 32'h12F45678);
        checkOutput("lbu_rdata", lastRspRdata, 32'h000000F4);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'b0, 0, 0, 32'h12F45678);
        checkOutput("lhu_rdata", lastRspRdata, 32'h000012F4);

        $display("[TB] misaligned and illegal accesses");
        base = memReqCycles;
        applyStimulus(1'b0, 3'b010, 32'h101, 32'b0, 0, 0, 32'b0);
        checkOutput("lw_mis_err", 32'(lastRspErr), 32'd1);
        checkOutput("lw_mis_latency", 32'(lastLatency), 32'd1);
        checkOutput("lw_mis_noreq", 32'(memReqCycles - base), 32'd0);
        base = memReqCycles;
        applyStimulus(1'b0, 3'b011, 32'h100, 32'b0, 0, 0, 32'b0);
        checkOutput("f3_011_err", 32'(lastRspErr), 32'd1);
        checkOutput("f3_011_latency", 32'(lastLatency), 32'd1);
        checkOutput("f3_011_noreq", 32'(memReqCycles - base), 32'd0);
        applyStimulus(1'b1, 3'b100, 32'h100, 32'h55, 0, 0, 32'b0);
        checkOutput("sbu_err", 32'(lastRspErr), 32'd1);
        applyStimulus(1'b0, 3'b001, 32'h103, 32'b0, 0, 0, 32'b0);

        $display("[TB] delayed grants and data, stray rvalid during issue");
        applyStimulus(1'b1, 3'b001, 32'h102, 32'hCAFEBEEF, 2, 0, 32'b0);
        checkOutput("sh_be", 32'(lastBe), 32'hC);
        checkOutput("sh_wdata", lastWdata, 32'hBEEFBEEF);
        strayRv = 1'b1;
        applyStimulus(1'b0, 3'b001, 32'h100, 32'b0, 1, 2, 32'h00008001);
        strayRv = 1'b0;
        checkOutput("lh_rdata", lastRspRdata, 32'hFFFF8001);
        applyStimulus(1'b0, 3'b010, 32'h104, 32'b0, 3, 1, 32'h89ABCDEF);
        checkOutput("lw_rdata", lastRspRdata, 32'h89ABCDEF);

        $display("[TB] timeouts");
        base = memReqCycles;
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h11, 100, 0, 32'b0);
        checkOutput("tmo_req_cycles", 32'(memReqCycles - base), 32'd15);
        checkOutput("tmo_err", 32'(lastRspErr), 32'd1);
        checkOutput("tmo_rdata", lastRspRdata, 32'd0);
        checkOutput("tmo_latency", 32'(lastLatency), 32'd16);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'b0, 0, 100, 32'b0);
        checkOutput("wait_tmo_err", 32'(lastRspErr), 32'd1);
        checkOutput("wait_tmo_latency", 32'(lastLatency), 32'd17);

        $display("[TB] reset while waiting for load data");
        base = rspCount;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'b0;
        setIdleExp(1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_funct3 = 3'b0; req_addr = 32'b0;
        setIdleExp(1'b0);
        expMemReq = 1'b1; expMemAddr = 32'h300; expMemBe = 4'hF;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h76543210;
        setIdleExp(1'b0);
        @(posedge clk); #1;
        reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
        setIdleExp(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reset_no_rsp", 32'(rspCount - base), 32'd0);

        $display("[TB] back-to-back word stores with grant held high");
        gntHold = 1'b1;
        mem_gnt = 1'b1;
        applyStimulus(1'b1, 3'b010, 32'h200, 32'h11112222, 0, 0, 32'b0);
        checkOutput("b2b0_latency", 32'(lastLatency), 32'd2);
        checkOutput("b2b0_be", 32'(lastBe), 32'hF);
        applyStimulus(1'b1, 3'b010, 32'h204, 32'h33334444, 0, 0, 32'b0);
        checkOutput("b2b1_latency", 32'(lastLatency), 32'd2);
        checkOutput("b2b1_be", 32'(lastBe), 32'hF);
        checkOutput("b2b1_addr", lastAddr, 32'h00000204);
        gntHold = 1'b0;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
